bc_iter_ctrl: RTL
=================

# bc_iter_ctrl

Parametrised iterative control block (BC) for the X/S/H operating block. It sequences the load enables `lx`, `ls`, `lh` and the operand-select `h` through a start/done-handshaked loop of `N_ITER` load→compute→accumulate iterations. It adds an iteration counter, abort, an optional auto-restart mode and a defined reset to the single-pass controller. It sits between the system-level sequencer (start/done) and the datapath register enables.

## Interface
- `N_ITER`, 8: iterations per run; legal range 1 ≤ N_ITER < 2^CNT_W.
- `CNT_W`, 4: width of the iteration counter and the `iter` output.
- `AUTO_RESTART`, 0: 1 = DONE goes straight to INIT when `start` is high; 0 = DONE always returns to IDLE.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE and, when AUTO_RESTART=1, in DONE.
- `abort` in 1: cancels a run in progress.
- `lx` out 1: load enable, X register.
- `ls` out 1: load enable, S register.
- `lh` out 1: load enable, H register.
- `h` out 1: operand mux select; 0 = initial values, 1 = loop values.
- `busy` out 1: run in progress (INIT, LOAD, CALC, ACC).
- `done` out 1: one-cycle completion pulse.
- `iter` out CNT_W: count of completed iterations.

## Operation
- State register is 3 bits: IDLE=000, INIT=001, LOAD=010, CALC=011, ACC=100, DONE=101.
- Encodings 110 and 111 are illegal. An illegal state goes to IDLE on the next edge with all outputs 0.
- Outputs are Moore outputs, decoded from the state register only. Any signal not listed for a state is 0.
  - IDLE: all 0. `start`=1 → INIT; otherwise stay in IDLE.
  - INIT: lx=ls=lh=1, h=0, busy=1. Clears `iter` to 0. → LOAD.
  - LOAD: lx=1, h=1, busy=1. → CALC.
  - CALC: lh=1, h=1, busy=1. → ACC.
  - ACC: ls=1, h=1, busy=1. `iter` increments by 1 on exit. If `iter` == N_ITER-1 while in ACC → DONE; otherwise → LOAD.
  - DONE: done=1. If AUTO_RESTART=1 and `start`=1 → INIT; otherwise → IDLE.
- Abort:
  - `abort`=1 in INIT, LOAD, CALC or ACC → IDLE on the next edge. No `done` pulse.
  - The ACC increment is suppressed when aborting, so `iter` keeps the count of completed iterations.
  - `abort` has priority over every other transition. It has no effect in IDLE or DONE.
- `start` is ignored while `busy`=1. No queuing.
- `iter` holds its value through DONE and IDLE until the next INIT. After a full run it equals N_ITER.
- Counter arithmetic is unsigned at CNT_W bits. It never wraps within the legal parameter range.

## Timing
- Reset (`rst_n`=0, asynchronous) forces: state IDLE, iter=0, lx=ls=lh=h=busy=done=0. Release is synchronous to `clk`.
- If reset is asserted mid-run, the run is abandoned immediately and no `done` pulse is produced.
- Latency: `start` sampled at edge 0.
  - INIT occupies cycle 1.
  - Iteration k (k = 0 .. N_ITER-1) occupies cycles 2+3k (LOAD), 3+3k (CALC) and 4+3k (ACC).
  - `done` is high in cycle 3·N_ITER+2; for N_ITER=8 that is cycle 26.
- `busy` is high for exactly 3·N_ITER+1 cycles per completed run.
- AUTO_RESTART back-to-back: `done` cycle is followed directly by INIT. No IDLE cycle between runs.
- N_ITER=1: sequence is INIT, LOAD, CALC, ACC, DONE. `done` in cycle 5, `iter`=1.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-CALC → all outputs 0 and iter=0 asynchronously; after release, with start=0, the block stays in IDLE for 10 cycles.
- Nominal run, N_ITER=8: 1-cycle `start` → INIT in cycle 1 (lx=ls=lh=1, h=0), then 8× {LOAD, CALC, ACC} enable patterns, `done` pulse in cycle 26, iter=8, busy low from cycle 26.
- Abort: pulse `abort` in CALC of iteration 3 (iter=2) → IDLE on the next edge, no `done`, iter stays 2; a later `start` restarts from INIT with iter=0.
- Start while busy: hold `start` high throughout the run with AUTO_RESTART=0 → exactly one `done`, then IDLE for one cycle, then INIT (start re-sampled in IDLE).
- AUTO_RESTART=1, `start` held high: `done` cycles at 26, 52, 78; INIT directly follows each `done`.
- N_ITER=1, CNT_W=1: `done` in cycle 5, iter=1. Force state 111 → IDLE on the next edge.

Source files
------------

// File: rtl/bc_iter_ctrl.sv
// Iterative control block for the X/S/H datapath: sequences lx/ls/lh and operand select h
// through N_ITER load/compute/accumulate iterations, with abort, iteration count and auto-restart.
module bc_iter_ctrl #(
    parameter int N_ITER       = 8,
    parameter int CNT_W        = 4,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             lx,
    output logic             ls,
    output logic             lh,
    output logic             h,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_INIT = 3'b001,
        S_LOAD = 3'b010,
        S_CALC = 3'b011,
        S_ACC  = 3'b100,
        S_DONE = 3'b101
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    // Plain vector rather than state_e so the unused encodings 110/111 stay representable.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    // NOTE: state registers use non-blocking assignments; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        lx      = 1'b0;
        ls      = 1'b0;
        lh      = 1'b0;
        h       = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                lx      = 1'b1;
                ls      = 1'b1;
                lh      = 1'b1;
                busy    = 1'b1;
                iter_d  = '0;
                state_d = abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                lx      = 1'b1;
                h       = 1'b1;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                lh      = 1'b1;
                h       = 1'b1;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_ACC;
            end
            S_ACC: begin
                ls   = 1'b1;
                h    = 1'b1;
                busy = 1'b1;
                // An aborted ACC leaves iter at the number of fully completed iterations.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = (iter_q == LAST_ITER) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = (AUTO_RESTART && start) ? S_INIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iter = iter_q;

endmodule
